// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared states, sizes and golden map for the 4-input truth-table checker
package tt_chk_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   localparam int N_VEC = 16;
   localparam int ERR_W = 5;
   // bit i holds the expected f for {a,b,c,d}=i, f = (a&b) ^ ~(c|d)
   localparam logic [N_VEC-1:0] GOLDEN_MAP = 16'hE111;
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: control/result bus and circuit-under-test pins of the checker
// TT_CHECKER_RESP_MAP_EN adds the resp_map response capture.
import tt_chk_pkg::*;
interface truth_table_checker_if;
   logic             start;
   logic             f_in;
   logic             a, b, c, d;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [3:0]       first_fail_vec;
   logic             first_fail_valid;
`ifdef TT_CHECKER_RESP_MAP_EN
   logic [N_VEC-1:0] resp_map;
   modport master (output start, f_in, input a, b, c, d, busy, done, pass, err_count,
                   first_fail_vec, first_fail_valid, resp_map);
   modport slave (input start, f_in, output a, b, c, d, busy, done, pass, err_count,
                  first_fail_vec, first_fail_valid, resp_map);
`else
   modport master (output start, f_in, input a, b, c, d, busy, done, pass, err_count,
                   first_fail_vec, first_fail_valid);
   modport slave (input start, f_in, output a, b, c, d, busy, done, pass, err_count,
                  first_fail_vec, first_fail_valid);
`endif
endinterface

// File: rtl/truth_table_checker_golden_lut.sv
// golden_lut: expected response of the target 4-input function for one vector
import tt_chk_pkg::*;
module golden_lut (
   input  logic [3:0] vec,
   output logic       exp
);
   assign exp = GOLDEN_MAP[vec];
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive 16-vector self-test sequencer with pass/fail, error count and first failure
// TT_CHECKER_RESP_MAP_EN adds the resp_map register of sampled responses.
import tt_chk_pkg::*;
module truth_table_checker #(
   parameter int SETTLE = 1
) (
   input logic clk,
   input logic rst,
   truth_table_checker_if.slave bus
);
   state_t           state_q, state_d;
   logic [3:0]       vec_q, vec_d, cnt_q, cnt_d, ffv_q, ffv_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ffval_q, ffval_d, pass_q, pass_d, busy_q, done_q, exp_f;
`ifdef TT_CHECKER_RESP_MAP_EN
   logic [N_VEC-1:0] map_q, map_d;
`endif
   golden_lut u_lut (.vec(vec_q), .exp(exp_f));
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffval_d = ffval_q;
      pass_d  = pass_q;
`ifdef TT_CHECKER_RESP_MAP_EN
      map_d   = map_q;
`endif
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = DRIVE;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            ffv_d   = '0;
            ffval_d = 1'b0;
            pass_d  = 1'b0;
`ifdef TT_CHECKER_RESP_MAP_EN
            map_d   = '0;
`endif
         end
         DRIVE: begin
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == 4'(SETTLE - 1)) ? SAMPLE : DRIVE;
         end
         SAMPLE: begin
`ifdef TT_CHECKER_RESP_MAP_EN
            map_d[vec_q] = bus.f_in;
`endif
            if (bus.f_in != exp_f) begin
               err_d = err_q + 1'b1;
               if (!ffval_q) begin
                  ffv_d   = vec_q;
                  ffval_d = 1'b1;
               end
            end
            if (vec_q == 4'd15) begin
               state_d = DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = DRIVE;
               vec_d   = vec_q + 4'd1;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffval_q <= 1'b0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef TT_CHECKER_RESP_MAP_EN
         map_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffval_q <= ffval_d;
         pass_q  <= pass_d;
         busy_q  <= (state_d == DRIVE) || (state_d == SAMPLE);
         done_q  <= (state_d == DONE);
`ifdef TT_CHECKER_RESP_MAP_EN
         map_q   <= map_d;
`endif
      end
   end
   assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffval_q;
`ifdef TT_CHECKER_RESP_MAP_EN
   assign bus.resp_map         = map_q;
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: scoreboard bench for truth_table_checker with SETTLE=1 and SETTLE=2 instances
import tt_chk_pkg::*;
module tb_truth_table_checker;
   typedef struct {
      logic [4:0]  err;
      logic [3:0]  ffv;
      logic        ffval;
      logic        pass;
      logic [15:0] map;
   } res_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode1 = 0;
   int   checks = 0;
   int   failures = 0;
   res_t sb1[$];
   res_t sb2[$];
   always #5 clk = ~clk;
   truth_table_checker_if bus1();
   truth_table_checker_if bus2();
   truth_table_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   truth_table_checker #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   // mode 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
   function automatic logic resp(int mode, logic [3:0] v);
      logic g;
      g = (v[3] & v[2]) ^ ~(v[1] | v[0]);
      return (mode == 0) ? g : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~g;
   endfunction
   always_comb bus1.f_in = resp(mode1, {bus1.a, bus1.b, bus1.c, bus1.d});
   always_comb bus2.f_in = resp(0, {bus2.a, bus2.b, bus2.c, bus2.d});
   function automatic res_t model(int mode);
      res_t r;
      r.err = '0; r.ffv = '0; r.ffval = 1'b0; r.map = '0;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         logic f;
         v = 4'(i);
         f = resp(mode, v);
         r.map[i] = f;
         if (f != resp(0, v)) begin
            if (!r.ffval) begin
               r.ffv = v;
               r.ffval = 1'b1;
            end
            r.err = r.err + 5'd1;
         end
      end
      r.pass = (r.err == 0);
      return r;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic score(input string tag, input res_t e, input logic [4:0] err, input logic [3:0] ffv,
                        input logic ffval, input logic pass, input logic [15:0] map);
      check({tag, "_err"}, 32'(err), 32'(e.err));
      check({tag, "_ffv"}, 32'(ffv), 32'(e.ffv));
      check({tag, "_ffval"}, 32'(ffval), 32'(e.ffval));
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
`ifdef TT_CHECKER_RESP_MAP_EN
      check({tag, "_map"}, 32'(map), 32'(e.map));
`else
      if (map !== map) check({tag, "_map"}, 32'(map), 32'(e.map));
`endif
   endtask
   task automatic run1(input int mode, input string tag);
      int   n;
      logic seen;
      res_t e;
      logic [15:0] m;
      @(negedge clk);
      mode1 = mode;
      bus1.start = 1'b1;
      sb1.push_back(model(mode));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1) bus1.start = 1'b0;
         seen = bus1.done;
         if (!seen) begin
            check({tag, "_busy"}, 32'(bus1.busy), 32'd1);
            check({tag, "_vec"}, 32'({bus1.a, bus1.b, bus1.c, bus1.d}), 32'((n - 1) / 2));
         end
      end
      check({tag, "_latency"}, 32'(n), 32'd33);
      m = '0;
`ifdef TT_CHECKER_RESP_MAP_EN
      m = bus1.resp_map;
`endif
      check({tag, "_sb_nonempty"}, 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
         e = sb1.pop_front();
         score(tag, e, bus1.err_count, bus1.first_fail_vec, bus1.first_fail_valid, bus1.pass, m);
         repeat (3) @(negedge clk);
         check({tag, "_done_pulse"}, 32'(bus1.done), 32'd0);
         check({tag, "_busy_after"}, 32'(bus1.busy), 32'd0);
         check({tag, "_hold_err"}, 32'(bus1.err_count), 32'(e.err));
         check({tag, "_hold_pass"}, 32'(bus1.pass), 32'(e.pass));
      end
   endtask
   initial begin
      int   n;
      int   runs;
      int   last;
      logic seen;
      logic [15:0] m;
      res_t e;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus1.busy), 32'd0);
      check("rst_done", 32'(bus1.done), 32'd0);
      check("rst_pass", 32'(bus1.pass), 32'd0);
      check("rst_err", 32'(bus1.err_count), 32'd0);
      check("rst_ffv", 32'(bus1.first_fail_vec), 32'd0);
      check("rst_ffval", 32'(bus1.first_fail_valid), 32'd0);
      check("rst_abcd", 32'({bus1.a, bus1.b, bus1.c, bus1.d}), 32'd0);
      check("rst_busy2", 32'(bus2.busy), 32'd0);
      rst = 1'b0;
      run1(0, "good");
      run1(1, "stuck0");
      run1(2, "stuck1");
      run1(3, "invert");
      @(negedge clk);
      mode1 = 1;
      bus1.start = 1'b1;
      sb1.push_back(model(1));
      n = 0;
      while ({bus1.a, bus1.b, bus1.c, bus1.d} != 4'd5 && n < 100) begin
         @(negedge clk);
         n++;
         bus1.start = 1'b0;
      end
      check("abort_reach_vec5", 32'({bus1.a, bus1.b, bus1.c, bus1.d}), 32'd5);
      check("abort_err_pre", 32'(bus1.err_count), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb1.pop_back());
      check("abort_busy", 32'(bus1.busy), 32'd0);
      check("abort_err", 32'(bus1.err_count), 32'd0);
      check("abort_abcd", 32'({bus1.a, bus1.b, bus1.c, bus1.d}), 32'd0);
      check("abort_done", 32'(bus1.done), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | bus1.done;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      run1(0, "after_abort");
      @(negedge clk);
      bus2.start = 1'b1;
      repeat (3) sb2.push_back(model(0));
      n = 0;
      runs = 0;
      last = 0;
      while (runs < 3 && n < 400) begin
         @(negedge clk);
         n++;
         if (bus2.done) begin
            runs++;
            check("held_period", 32'(n - last), (runs == 1) ? 32'd49 : 32'd50);
            last = n;
            m = '0;
`ifdef TT_CHECKER_RESP_MAP_EN
            m = bus2.resp_map;
`endif
            if (sb2.size() != 0) begin
               e = sb2.pop_front();
               score("held", e, bus2.err_count, bus2.first_fail_vec, bus2.first_fail_valid, bus2.pass, m);
            end
         end
      end
      check("held_runs", 32'(runs), 32'd3);
      bus2.start = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable self-test sequencer: the hardware counterpart of our exhaustive 4-input logic benches.
- Drives all 16 input vectors {a,b,c,d} onto a combinational circuit-under-test and samples its response f_in.
- Compares each response against the golden function f = (a&b) ^ ~(c|d) and reports pass/fail, error count and first failing vector.
- Sits beside the circuit-under-test; a controller or top-level bench triggers it with start.

Parameters:
- SETTLE, 1, cycles each vector is held before sampling f_in; legal range 1..15.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  run request; sampled only in IDLE.
- f_in  input  1  response from the circuit-under-test.
- a, b, c, d  output  1 each  stimulus to the circuit-under-test; {a,b,c,d} = vec[3:0], with a as MSB.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  err_count==0 for the last completed run.
- err_count  output  5  mismatches in the last or current run, 0..16.
- first_fail_vec  output  4  index of the first mismatching vector.
- first_fail_valid  output  1  at least one mismatch seen this run.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; vec=0; settle_cnt=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
  - Reset mid-run aborts the run immediately with the same values; no done pulse.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1 -> DRIVE, with vec=0, settle_cnt=0, err_count=0, first_fail_valid=0, first_fail_vec=0, pass=0.
- DRIVE:
  - vec is stable on a..d.
  - settle_cnt increments each cycle; when settle_cnt==SETTLE-1 -> SAMPLE.
  - Duration is exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - exp = GOLDEN_MAP[vec].
  - If f_in!=exp: err_count+=1; if first_fail_valid==0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec==15 -> DONE; else vec+=1, settle_cnt=0 -> DRIVE.
- DONE (1 cycle):
  - done=1; pass=(err_count==0), registered so it is valid in the same cycle as done.
  - Then -> IDLE. vec stays at 15 until the next start.
- Timing:
  - Each vector costs SETTLE+1 cycles.
  - With start asserted at edge 0, done is high during cycle 16*(SETTLE+1)+1 (33 for SETTLE=1).
- start handling:
  - Ignored in DRIVE, SAMPLE and DONE.
  - Held continuously, it gives back-to-back runs with period 16*(SETTLE+1)+2 (one IDLE cycle between runs).
- Result hold: err_count, pass and first_fail_* hold their values after DONE until the next accepted start.
- Counter widths:
  - err_count cannot exceed 16, so no saturation logic.
  - vec increment wraps only via state change, never arithmetically.
- Outputs a..d, busy and done are registered (no combinational path from f_in).

Optional Feature:
- Macro: TT_CHECKER_RESP_MAP_EN.
- Defined:
  - Adds output resp_map[15:0]; bit vec is written with the sampled f_in in each SAMPLE.
  - Cleared on start accept and on reset.
  - A correct circuit yields 16'hE111.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package tt_chk_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, DONE}.
  - N_VEC=16.
  - GOLDEN_MAP=16'hE111 (bit i = expected f for {a,b,c,d}=i).
  - ERR_W=5.
- One sub-module: golden_lut, combinational; input vec[3:0], output exp = GOLDEN_MAP[vec]. Swapping it retargets the checker to another 4-input function.

Test Plan:
- Correct model on f_in, SETTLE=1, start pulse -> done at cycle 33; pass=1, err_count=0, first_fail_valid=0, resp_map=16'hE111.
- f_in stuck at 0 -> err_count=6, first_fail_vec=0, pass=0, resp_map=16'h0000.
- f_in stuck at 1 -> err_count=10, first_fail_vec=1, pass=0.
- f_in = inverted golden -> err_count=16, first_fail_vec=0, first_fail_valid=1.
- rst pulsed while vec==5 -> next cycle: busy=0, err_count=0, a..d=0, no done. New start -> clean run, pass=1.
- start held high with SETTLE=2 -> done pulses every 16*3+2=50 cycles; each run reports pass=1; start pulses during busy have no effect.
